// File: rtl/regfile_wb_pkg.sv
// Shared constants for the write-back stage and its register file.
package regfile_wb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_array.sv
// Register storage: one write port, three asynchronous read ports, synchronous clear.
module regfile_array
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra_a,
  input  logic [ADDR_W-1:0] ra_b,
  input  logic [ADDR_W-1:0] ra_c,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] rd_c
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: every entry is cleared on reset, so this storage maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we && (wa != ZERO_IDX)) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd_a = (ra_a == ZERO_IDX) ? '0 : mem_q[ra_a];
  assign rd_b = (ra_b == ZERO_IDX) ? '0 : mem_q[ra_b];
  assign rd_c = (ra_c == ZERO_IDX) ? '0 : mem_q[ra_c];
endmodule

// File: rtl/regfile_wb.sv
// WB pipeline register, commit logic, bypassed read ports and commit counter.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_wa,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_wa,
  output logic [DATA_W-1:0] wb_wd,
  output logic [31:0]       commit_cnt
);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_wa_q, wb_wa_d;
  logic [DATA_W-1:0] wb_wd_q, wb_wd_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              commit;
  logic [DATA_W-1:0] arr_rd1, arr_rd2;

  // NOTE: next-state logic uses blocking '=' with defaults first so no latch is inferred.
  always_comb begin
    wb_we_d = wb_we_q;
    wb_wa_d = wb_wa_q;
    wb_wd_d = wb_wd_q;
    if (flush) begin
      wb_we_d = 1'b0;
      wb_wa_d = '0;
      wb_wd_d = '0;
    end else if (!stall) begin
      wb_we_d = mem_we;
      wb_wa_d = mem_wa;
      wb_wd_d = mem_wd;
    end
  end

  assign commit = wb_we_q & ~stall & ~flush & ~rst & (wb_wa_q != ZERO_IDX);
  assign cnt_d  = commit ? cnt_q + 32'd1 : cnt_q;

  // NOTE: state registers use non-blocking '<=' so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we_q <= 1'b0;
      wb_wa_q <= '0;
      wb_wd_q <= '0;
      cnt_q   <= '0;
    end else begin
      wb_we_q <= wb_we_d;
      wb_wa_q <= wb_wa_d;
      wb_wd_q <= wb_wd_d;
      cnt_q   <= cnt_d;
    end
  end

  regfile_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (commit),
    .wa   (wb_wa_q),
    .wd   (wb_wd_q),
    .ra_a (ra1),
    .ra_b (ra2),
    .ra_c (dbg_addr),
    .rd_a (arr_rd1),
    .rd_b (arr_rd2),
    .rd_c (dbg_data)
  );

  // Bypass forwards the pending write regardless of stall, but not while it is being flushed.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra,
                                                  input logic [DATA_W-1:0] arr_val);
    if (ra == ZERO_IDX)                          return '0;
    if (wb_we_q && !flush && (wb_wa_q == ra))    return wb_wd_q;
    return arr_val;
  endfunction

  assign rd1        = read_port(ra1, arr_rd1);
  assign rd2        = read_port(ra2, arr_rd2);
  assign wb_we      = wb_we_q;
  assign wb_wa      = wb_wa_q;
  assign wb_wd      = wb_wd_q;
  assign commit_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed plan steps then random traffic against a reference model.
module tb_regfile_wb;
  logic        clk = 1'b0;
  logic        rst, stall, flush, mem_we;
  logic [4:0]  mem_wa, ra1, ra2, dbg_addr;
  logic [31:0] mem_wd;
  logic [31:0] rd1, rd2, dbg_data, wb_wd, commit_cnt;
  logic        wb_we;
  logic [4:0]  wb_wa;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: architectural registers, pending WB slot, commit count.
  logic [31:0] m_arr [32];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_cnt;
  logic [31:0] base;

  regfile_wb dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic byp_ok);
    if (a == 5'd0) return 32'd0;
    if (byp_ok && m_we && m_wa == a) return m_wd;
    return m_arr[a];
  endfunction

  task automatic apply(input logic r, input logic s, input logic f, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
    rst = r; stall = s; flush = f; mem_we = we; mem_wa = wa; mem_wd = wd;
    ra1 = a1; ra2 = a2; dbg_addr = da;
    #1;
  endtask

  task automatic compare_all();
    check("rd1", rd1, exp_read(ra1, !flush));
    check("rd2", rd2, exp_read(ra2, !flush));
    check("dbg_data", dbg_data, exp_read(dbg_addr, 1'b0));
    check("wb_we", 32'(wb_we), 32'(m_we));
    check("wb_wa", 32'(wb_wa), 32'(m_wa));
    check("wb_wd", wb_wd, m_wd);
    check("commit_cnt", commit_cnt, m_cnt);
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_arr[i] = 32'd0;
      m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_cnt = 32'd0;
    end else begin
      if (m_we && !stall && !flush && m_wa != 5'd0) begin
        m_arr[m_wa] = m_wd;
        m_cnt       = m_cnt + 32'd1;
      end
      if (flush) begin
        m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
      end else if (!stall) begin
        m_we = mem_we; m_wa = mem_wa; m_wd = mem_wd;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
    apply(r, s, f, we, wa, wd, a1, a2, da);
    compare_all();
    tick();
  endtask

  initial begin
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Reset: fill a few registers, then reset and sweep every index.
    step(0, 0, 0, 1, 5'd4, 32'h1111_0004, 4, 6, 4);
    step(0, 0, 0, 1, 5'd6, 32'h2222_0006, 4, 6, 4);
    step(0, 0, 0, 1, 5'd31, 32'h3333_001F, 4, 6, 6);
    step(0, 0, 0, 0, 5'd0, 32'h0, 31, 6, 4);
    step(1, 0, 0, 1, 5'd8, 32'hFFFF_FFFF, 4, 6, 31);
    for (int i = 0; i < 32; i++) begin
      apply(0, 0, 0, 0, 0, 0, 5'(i), 5'(i), 5'(i));
      check("rst_rd1", rd1, 32'd0);
      check("rst_rd2", rd2, 32'd0);
      check("rst_dbg", dbg_data, 32'd0);
    end
    check("rst_cnt", commit_cnt, 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);

    // Basic path through bypass then array.
    step(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 5, 0, 5);
    apply(0, 0, 0, 0, 0, 0, 5, 0, 5);
    check("basic_bypass", rd1, 32'hDEAD_BEEF);
    check("basic_dbg_pre", dbg_data, 32'd0);
    compare_all();
    tick();
    apply(0, 0, 0, 0, 0, 0, 5, 0, 5);
    check("basic_rd1", rd1, 32'hDEAD_BEEF);
    check("basic_dbg_post", dbg_data, 32'hDEAD_BEEF);
    check("basic_cnt", commit_cnt, 32'd1);

    // Writes to r0 are dropped and not counted.
    step(0, 0, 0, 1, 5'd0, 32'h1234_5678, 0, 0, 0);
    step(0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("r0_rd1", rd1, 32'd0);
    check("r0_cnt", commit_cnt, 32'd1);

    // Stall holds the pending write; exactly one commit on release.
    step(0, 0, 0, 1, 5'd7, 32'h0000_00A5, 7, 0, 7);
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 1, 5'd12, 32'hBAD0_0000, 7, 12, 7);
      check("stall_bypass", rd1, 32'h0000_00A5);
      check("stall_dbg", dbg_data, 32'd0);
      compare_all();
      tick();
    end
    step(0, 0, 0, 0, 5'd0, 32'h0, 7, 0, 7);
    apply(0, 0, 0, 0, 0, 0, 7, 0, 7);
    check("stall_dbg_post", dbg_data, 32'h0000_00A5);
    check("stall_cnt", commit_cnt, 32'd2);

    // Flush overrides stall and cancels the pending write.
    step(0, 0, 0, 1, 5'd9, 32'h0000_0055, 9, 0, 9);
    apply(0, 1, 1, 0, 0, 0, 9, 0, 9);
    check("flush_no_bypass", rd1, 32'd0);
    compare_all();
    tick();
    apply(0, 0, 0, 0, 0, 0, 9, 0, 9);
    check("flush_wb_we", 32'(wb_we), 32'd0);
    check("flush_dbg", dbg_data, 32'd0);
    check("flush_cnt", commit_cnt, 32'd2);
    compare_all();
    tick();

    // Back-to-back writes to the same register.
    step(0, 0, 0, 1, 5'd3, 32'd1, 3, 0, 3);
    apply(0, 0, 0, 1, 5'd3, 32'd2, 3, 0, 3);
    check("b2b_first", rd1, 32'd1);
    compare_all();
    tick();
    apply(0, 0, 0, 0, 0, 0, 3, 0, 3);
    check("b2b_second", rd1, 32'd2);
    compare_all();
    tick();
    apply(0, 0, 0, 0, 0, 0, 3, 0, 3);
    check("b2b_dbg", dbg_data, 32'd2);
    check("b2b_cnt", commit_cnt, 32'd4);

    // Reset mid-stream discards the pending write.
    step(0, 0, 0, 1, 5'd11, 32'hCAFE_F00D, 11, 3, 11);
    step(1, 0, 0, 1, 5'd12, 32'h0BAD_0BAD, 11, 3, 11);
    apply(0, 0, 0, 0, 0, 0, 11, 3, 11);
    check("mid_rst_rd1", rd1, 32'd0);
    check("mid_rst_wb_we", 32'(wb_we), 32'd0);
    check("mid_rst_cnt", commit_cnt, 32'd0);

    // Random traffic against the model.
    base = m_cnt;
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)),
           32'($urandom),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)),
           5'($urandom_range(0, 7)));
    end
    apply(0, 0, 0, 0, 0, 0, 1, 2, 3);
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
